// File: rtl/matrix_result_serializer_4x4_complex.sv
// Captures the 4x4 complex product matrix on start and streams it out as 32
// sign-extended words (row-major, real before imag) over valid/ready.
module matrix_result_serializer_4x4_complex #(
    parameter  int w         = 4,
    parameter  int OUT_W     = 16,
    localparam int WIDTH_OUT = 2*w+3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [3:0][3:0][WIDTH_OUT-1:0]      C_real,
    input  logic [3:0][3:0][WIDTH_OUT-1:0]      C_imag,
    output logic                                busy,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [OUT_W-1:0]                    m_data,
    output logic [1:0]                          m_row,
    output logic [1:0]                          m_col,
    output logic                                m_is_imag,
    output logic                                m_last,
    output logic                                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [3:0][3:0][WIDTH_OUT-1:0] elem_arr_t;

    function automatic logic [OUT_W-1:0] sext(input logic [WIDTH_OUT-1:0] x);
        return {{(OUT_W-WIDTH_OUT){x[WIDTH_OUT-1]}}, x};
    endfunction

    // Beat b selects element [b[4:3]][b[2:1]], imaginary part when b[0] is set.
    function automatic logic [OUT_W-1:0] pick(input elem_arr_t re, input elem_arr_t im,
                                               input logic [4:0] b);
        return b[0] ? sext(im[b[4:3]][b[2:1]]) : sext(re[b[4:3]][b[2:1]]);
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       k_q, k_d;
    elem_arr_t        snap_re_q, snap_re_d;
    elem_arr_t        snap_im_q, snap_im_d;
    logic             busy_q, busy_d;
    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [1:0]       m_row_q, m_row_d;
    logic [1:0]       m_col_q, m_col_d;
    logic             m_is_imag_q, m_is_imag_d;
    logic             m_last_q, m_last_d;
    logic             done_q, done_d;
    logic [4:0]       nk_s;

    // Next-state and next-output logic; every output field is registered.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        snap_re_d   = snap_re_q;
        snap_im_d   = snap_im_q;
        busy_d      = busy_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_row_d     = m_row_q;
        m_col_d     = m_col_q;
        m_is_imag_d = m_is_imag_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;
        nk_s        = k_q + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_re_d   = C_real;
                    snap_im_d   = C_imag;
                    k_d         = 5'd0;
                    state_d     = S_SEND;
                    busy_d      = 1'b1;
                    m_valid_d   = 1'b1;
                    // Snapshot is not yet readable, so beat 0 comes straight from the inputs.
                    m_data_d    = pick(C_real, C_imag, 5'd0);
                    m_row_d     = 2'd0;
                    m_col_d     = 2'd0;
                    m_is_imag_d = 1'b0;
                    m_last_d    = 1'b0;
                end else begin
                    busy_d    = 1'b0;
                    m_valid_d = 1'b0;
                end
            end
            S_SEND: begin
                if (m_valid_q && m_ready) begin
                    if (k_q == 5'd31) begin
                        state_d     = S_DONE;
                        m_valid_d   = 1'b0;
                        m_data_d    = {OUT_W{1'b0}};
                        m_row_d     = 2'd0;
                        m_col_d     = 2'd0;
                        m_is_imag_d = 1'b0;
                        m_last_d    = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        k_d         = nk_s;
                        m_data_d    = pick(snap_re_q, snap_im_q, nk_s);
                        m_row_d     = nk_s[4:3];
                        m_col_d     = nk_s[2:1];
                        m_is_imag_d = nk_s[0];
                        m_last_d    = (nk_s == 5'd31);
                    end
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 5'd0;
            snap_re_q   <= '0;
            snap_im_q   <= '0;
            busy_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= {OUT_W{1'b0}};
            m_row_q     <= 2'd0;
            m_col_q     <= 2'd0;
            m_is_imag_q <= 1'b0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            snap_re_q   <= snap_re_d;
            snap_im_q   <= snap_im_d;
            busy_q      <= busy_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_row_q     <= m_row_d;
            m_col_q     <= m_col_d;
            m_is_imag_q <= m_is_imag_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_row     = m_row_q;
    assign m_col     = m_col_q;
    assign m_is_imag = m_is_imag_q;
    assign m_last    = m_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matrix_result_serializer_4x4_complex.sv
// Scoreboard bench: a negedge monitor models the IDLE/SEND/DONE protocol, pushes
// 32 expected words on each accepted start and pops them on every handshake.
module tb_matrix_result_serializer_4x4_complex;

    localparam int W  = 4;
    localparam int WO = 2*W+3;
    localparam int OW = 16;

    typedef enum logic [1:0] {M_IDLE, M_SEND, M_DONE, M_END} mstate_t;

    logic                    clk = 1'b0;
    logic                    rst, start, m_ready;
    logic [3:0][3:0][WO-1:0] c_real, c_imag;
    logic                    busy, m_valid, m_is_imag, m_last, done;
    logic [OW-1:0]           m_data;
    logic [1:0]              m_row, m_col;

    int      n_cmp = 0;
    int      n_err = 0;
    logic [21:0] sb[$];
    mstate_t ms = M_IDLE;
    int      beats = 0;
    int      streams = 0;
    logic    stalled = 1'b0;
    logic [21:0] held;

    matrix_result_serializer_4x4_complex #(.w(W), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .C_real(c_real), .C_imag(c_imag),
        .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_is_imag(m_is_imag), .m_last(m_last),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [21:0] cur_word();
        return {m_last, m_is_imag, m_row, m_col, m_data};
    endfunction

    // Expected stream for a capture of the current inputs.
    task automatic push_stream();
        logic [4:0] b;
        logic signed [OW-1:0] v;
        for (int i = 0; i < 32; i++) begin
            b = i[4:0];
            if (b[0]) v = $signed(c_imag[b[4:3]][b[2:1]]);
            else      v = $signed(c_real[b[4:3]][b[2:1]]);
            sb.push_back({(b == 5'd31), b[0], b[4:3], b[2:1], v});
        end
        beats = 0;
    endtask

    // Protocol model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ms      = M_IDLE;
            stalled = 1'b0;
        end else begin
            if (done && ms != M_DONE) chk("spurious_done", {31'd0, done}, 32'd0);
            if (stalled) begin
                chk("stall_hold", {10'd0, cur_word()}, {10'd0, held});
                stalled = 1'b0;
            end
            case (ms)
                M_IDLE: begin
                    chk("idle_out", {30'd0, busy, m_valid}, 32'd0);
                    if (start) begin
                        push_stream();
                        ms = M_SEND;
                    end
                end
                M_SEND: begin
                    chk("send_busy_valid", {30'd0, busy, m_valid}, 32'd3);
                    if (m_valid && m_ready) begin
                        if (sb.size() == 0) begin
                            chk("sb_underflow", 32'd1, 32'd0);
                        end else begin
                            held = sb.pop_front();
                            chk("beat", {10'd0, cur_word()}, {10'd0, held});
                            beats++;
                            if (held[21]) begin
                                chk("hs_count", beats, 32'd32);
                                ms = M_DONE;
                            end
                        end
                    end else if (m_valid) begin
                        held    = cur_word();
                        stalled = 1'b1;
                    end
                end
                M_DONE: begin
                    chk("done_pulse", {29'd0, done, busy, m_valid}, 32'd6);
                    ms = M_END;
                end
                M_END: begin
                    chk("done_clear", {29'd0, done, busy, m_valid}, 32'd0);
                    streams++;
                    ms = M_IDLE;
                    if (start) begin
                        push_stream();
                        ms = M_SEND;
                    end
                end
                default: ms = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; 1: ready 1,0,0 pattern; 2: ready high, inputs scrambled, start pulsed in SEND
    task automatic wait_idle(input int mode);
        int n = 0;
        while (!(ms == M_IDLE && sb.size() == 0) && n < 500) begin
            case (mode)
                1: m_ready = ((n % 3) == 0);
                2: begin
                    m_ready = 1'b1;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++) begin
                            c_real[i][j] = WO'($urandom);
                            c_imag[i][j] = WO'($urandom);
                        end
                    start = (ms == M_SEND && beats < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                default: m_ready = 1'b1;
            endcase
            tick();
            n++;
        end
        if (n >= 500) chk("timeout", 32'd0, 32'd1);
        start   = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        rst = 1'b1; start = 1'b0; m_ready = 1'b1;
        c_real = '0; c_imag = '0;
        repeat (3) tick();
        chk("rst_out", {7'd0, busy, m_valid, m_data, m_row, m_col, m_is_imag, m_last, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Identity data, with done latency measured from the start edge.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c_real[i][j] = WO'(4*i + j);
                c_imag[i][j] = WO'(-(4*i + j));
            end
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_latency", n, 32'd33);
        wait_idle(0);

        // Extreme values.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c_real[i][j] = 11'h400;
                c_imag[i][j] = 11'h3FF;
            end
        pulse_start();
        wait_idle(0);

        // Backpressure.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c_real[i][j] = WO'($urandom);
                c_imag[i][j] = WO'($urandom);
            end
        m_ready = 1'b1;
        pulse_start();
        wait_idle(1);

        // Inputs scrambled after capture and start pulsed during SEND.
        pulse_start();
        wait_idle(2);

        // Reset at beat 10, then a fresh full stream.
        s0 = streams;
        pulse_start();
        n = 0;
        while (beats < 10 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        chk("rst_mid_out", {7'd0, busy, m_valid, m_data, m_row, m_col, m_is_imag, m_last, done}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("rst_no_stream", streams - s0, 32'd0);
        pulse_start();
        wait_idle(0);
        chk("rst_restart", streams - s0, 32'd1);

        // start held high continuously.
        s0 = streams;
        start = 1'b1;
        n = 0;
        while (streams < s0 + 2 && n < 300) begin
            tick();
            n++;
        end
        start = 1'b0;
        wait_idle(0);
        chk("b2b_streams", streams - s0, 32'd3);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
